// File: rtl/neuron_sequencer.sv
// Control sequencer for the neuron MAC datapath: clears the accumulator, walks LEN x/w element
// pairs through fetch and multiply-accumulate, then runs activation and stores the result.
module neuron_sequencer #(
  parameter int unsigned Q   = 4,
  parameter int unsigned d   = 2,
  parameter int unsigned LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [d-1:0] dim_sel,
  output logic         busy,
  output logic         done,
  output logic         clear_acc,
  output logic         acc_en,
  output logic         memRead_x,
  output logic         memRead_w,
  output logic         x_write,
  output logic         w_write,
  output logic         res_write,
  output logic         ready,
  output logic [Q-1:0] addr_x,
  output logic [Q-1:0] addr_w,
  output logic [d-1:0] index_d_x,
  output logic [d-1:0] index_d_w
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StMac,
    StAct,
    StStore,
    StDone
  } state_e;

  localparam logic [Q-1:0] LastIdx = Q'(LEN - 1);

  state_e         state_q, state_d;
  logic [Q-1:0]   cnt_q, cnt_d;
  logic [d-1:0]   idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = dim_sel;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: state_d = StFetch;
      StFetch: state_d = StMac;
      StMac: begin
        // Terminal compare comes before the increment, so the counter never wraps.
        if (cnt_q == LastIdx) begin
          state_d = StAct;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StFetch;
        end
      end
      StAct:   state_d = StStore;
      StStore: state_d = StDone;
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = 1'b0;
    clear_acc = 1'b0;
    acc_en    = 1'b0;
    memRead_x = 1'b0;
    memRead_w = 1'b0;
    x_write   = 1'b0;
    w_write   = 1'b0;
    res_write = 1'b0;
    ready     = 1'b0;
    unique case (state_q)
      StClear: clear_acc = 1'b1;
      StFetch: begin
        memRead_x = 1'b1;
        memRead_w = 1'b1;
        x_write   = 1'b1;
        w_write   = 1'b1;
      end
      StMac:   acc_en = 1'b1;
      StAct:   ready = 1'b1;
      StStore: begin
        ready     = 1'b1;
        res_write = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign addr_x    = cnt_q;
  assign addr_w    = cnt_q;
  assign index_d_x = idx_q;
  assign index_d_w = idx_q;

endmodule
